// File: rtl/mult_pkg.sv
// Shared widths and the round-robin pick function for the shared multiplier arbiter.
package mult_pkg;

  localparam int MULT_W  = 16;
  localparam int PROD_W  = 32;
  localparam int MAX_REQ = 4;

  // Returns the first valid index searching upward from last+1, wrapping at n_req.
  function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [1:0]         last,
                                         input int                 n_req);
    logic [1:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n_req;
      if (k <= n_req && !found && valid[2'(idx)]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational signed 16x16 multiplier: radix-4 Booth partial products summed into a full 32-bit product.
module mult_core
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic        [MULT_W:0]   b_ext;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] pp;
  logic signed [PROD_W-1:0] acc;

  assign a_ext = PROD_W'(signed'(a));

  // NOTE: every variable gets a default before the loop so no latch is inferred; blocking '=' is correct here.
  always_comb begin
    b_ext = {b, 1'b0};
    pp    = '0;
    acc   = '0;
    for (int i = 0; i < MULT_W / 2; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
  end

  assign p = acc;

endmodule

// File: rtl/rr_arb.sv
// Round-robin picker with its last-grant pointer; grants only when the pipeline can accept.
module rr_arb
  import mult_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             accept,
  output logic [N_REQ-1:0] ready,
  output logic [ID_W-1:0]  grant
);

  logic [ID_W-1:0] last;
  logic            any;

  assign any   = |valid;
  assign grant = ID_W'(rr_pick(MAX_REQ'(valid), 2'(last), N_REQ));
  assign ready = (any && accept) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant) : '0;

  // Pointer starts at the top index so requester 0 wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last <= ID_W'(N_REQ - 1);
    else if (any && accept) last <= grant;
  end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin shared multiplier: operand register, product register, one tagged valid/ready result port.
module mult_rr_arbiter
  import mult_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [MULT_W*N_REQ-1:0] req_a,
  input  logic [MULT_W*N_REQ-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [PROD_W-1:0]       res_data
);

  logic              s1_vld, s2_vld;
  logic [MULT_W-1:0] s1_a, s1_b;
  logic [ID_W-1:0]   s1_id, s2_id;
  logic [PROD_W-1:0] s2_data, prod;
  logic              stall, adv1, accept, hs;
  logic [ID_W-1:0]   grant;
  logic [MULT_W-1:0] a_sel, b_sel;

  assign stall  = s2_vld & ~res_ready;
  assign adv1   = ~stall;
  assign accept = ~stall | ~s1_vld;
  assign hs     = |(req_valid & req_ready);

  // Gating with rst keeps req_ready at 0 while reset is held.
  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept & ~rst),
    .ready  (req_ready),
    .grant  (grant)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        a_sel = req_a[MULT_W*i +: MULT_W];
        b_sel = req_b[MULT_W*i +: MULT_W];
      end
    end
  end

  mult_core u_core (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // NOTE: data registers are reset too (they are few and drive outputs directly), so every output is 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_id   <= '0;
      s2_vld  <= 1'b0;
      s2_data <= '0;
      s2_id   <= '0;
    end else begin
      if (accept) begin
        s1_vld <= hs;
        if (hs) begin
          s1_a  <= a_sel;
          s1_b  <= b_sel;
          s1_id <= grant;
        end
      end
      if (adv1) begin
        s2_vld  <= s1_vld;
        s2_data <= prod;
        s2_id   <= s1_id;
      end
    end
  end

  assign res_valid = s2_vld;
  assign res_data  = s2_data;
  assign res_id    = s2_id;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Bench for mult_rr_arbiter (N_REQ=2): directed vectors and corner sequences plus a random scoreboard run.
module tb_mult_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        res_valid;
  logic        res_ready;
  logic [0:0]  res_id;
  logic [31:0] res_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] p;
    int          stage;
  } item_t;

  vec_t  vecs[7];
  item_t q[$];

  always #5 clk = ~clk;

  mult_rr_arbiter #(.N_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] ea[10], eb[10];
    logic [15:0] ra[2], rb[2];
    logic [1:0]  v;
    int          last_m;

    vecs[0] = '{16'h0003, 16'hFFFB, 32'hFFFF_FFF1};
    vecs[1] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[2] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
    vecs[4] = '{16'h0000, 16'h8000, 32'h0000_0000};
    vecs[5] = '{16'h8000, 16'h7FFF, 32'hC000_8000};
    vecs[6] = '{16'h1234, 16'h0010, 32'h0001_2340};

    // Reset state and table-driven single products through requester 0.
    reset_dut();
    #1;
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_res_data", res_data, 32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_valid = 2'b01;
      req_a     = {16'h0, vecs[i].a};
      req_b     = {16'h0, vecs[i].b};
      #1;
      check("vec_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b00;
      tick();
      check("vec_res_valid", 32'(res_valid), 32'd1);
      check("vec_res_id", 32'(res_id), 32'd0);
      check("vec_res_data", res_data, vecs[i].p);
    end

    // Contention: both valid every cycle, grants alternate with no bubbles.
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      ea[k] = 16'(k * 311 + 5);
      eb[k] = 16'(-97 * k - 3);
    end
    res_ready = 1'b1;
    req_valid = 2'b11;
    req_a     = {ea[1], ea[0]};
    req_b     = {eb[1], eb[0]};
    for (int k = 0; k < 8; k++) begin
      #1;
      check("cont_req_ready", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      check("cont_res_valid", 32'(res_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check("cont_res_id", 32'(res_id), 32'((k - 2) % 2));
        check("cont_res_data", res_data, prod(ea[k-2], eb[k-2]));
      end
      tick();
      req_a[16*(k%2) +: 16] = ea[k+2];
      req_b[16*(k%2) +: 16] = eb[k+2];
    end

    // Backpressure with two items in flight.
    reset_dut();
    res_ready = 1'b1;
    req_valid = 2'b01;
    req_a = {16'h0, 16'h0101}; req_b = {16'h0, 16'hFF00};
    #1;
    check("bp_ready_x1", 32'(req_ready), 32'd1);
    tick();
    req_a = {16'h0, 16'h0202}; req_b = {16'h0, 16'h0033};
    res_ready = 1'b0;
    #1;
    check("bp_ready_x2", 32'(req_ready), 32'd1);
    tick();
    req_a = {16'h0, 16'h8000}; req_b = {16'h0, 16'h0003};
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_data", res_data, prod(16'h0101, 16'hFF00));
      check("bp_hold_id", 32'(res_id), 32'd0);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_rel_data", res_data, prod(16'h0101, 16'hFF00));
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    #1;
    check("bp_drain2_valid", 32'(res_valid), 32'd1);
    check("bp_drain2_data", res_data, prod(16'h0202, 16'h0033));
    tick();
    check("bp_drain3_valid", 32'(res_valid), 32'd1);
    check("bp_drain3_data", res_data, prod(16'h8000, 16'h0003));
    tick();
    check("bp_empty", 32'(res_valid), 32'd0);

    // Reset mid-operation with both stages full and the pointer on requester 0.
    reset_dut();
    res_ready = 1'b0;
    req_valid = 2'b10;
    req_a = {16'h0011, 16'h0022}; req_b = {16'h0033, 16'h0044};
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    #1;
    check("mid_full_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_data", res_data, 32'd0);
    check("mid_rst_id", 32'(res_id), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_first_grant", 32'(req_ready), 32'd1);
    res_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    check("mid_no_stale", 32'(res_valid), 32'd0);
    tick();
    check("mid_res_valid", 32'(res_valid), 32'd1);
    check("mid_res_id", 32'(res_id), 32'd0);
    check("mid_res_data", res_data, prod(16'h0022, 16'h0044));

    // Random scoreboard against a transaction-level model.
    reset_dut();
    q.delete();
    v      = 2'b00;
    last_m = 1;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic exp_rv, m_stall, s1_full, m_acc;
      int   g;
      logic [1:0] exp_ready;
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            v[i]  = 1'b1;
            ra[i] = pick_op();
            rb[i] = pick_op();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      req_valid = v;
      req_a     = {ra[1], ra[0]};
      req_b     = {rb[1], rb[0]};
      #1;
      exp_rv  = (q.size() > 0) && (q[0].stage == 2);
      m_stall = exp_rv && !res_ready;
      s1_full = (q.size() > 0) && (q[$].stage == 1);
      m_acc   = !m_stall || !s1_full;
      g = -1;
      for (int k = 1; k <= 2; k++) begin
        int idx;
        idx = (last_m + k) % 2;
        if (g < 0 && v[idx]) g = idx;
      end
      exp_ready = (m_acc && g >= 0) ? 2'(1 << g) : 2'b00;
      check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
      check("rnd_res_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_rv) begin
        check("rnd_res_id", 32'(res_id), 32'(q[0].id));
        check("rnd_res_data", res_data, q[0].p);
      end
      if (exp_rv && res_ready) void'(q.pop_front());
      if (!m_stall) begin
        foreach (q[j]) if (q[j].stage == 1) q[j].stage = 2;
      end
      if (exp_ready != 2'b00) begin
        q.push_back('{g, prod(ra[g], rb[g]), 1});
        last_m = g;
        v[g]   = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
